// File: rtl/pad_bank_pkg.sv
// pad_bank_pkg: shared constants, parameter range checks and the per-channel
// state bundle used by pad_bank_ctrl and pad_bank_chan.
//   MAX_WIDTH           largest supported number of channels in one bank
//   FILTER_CNT_W        width of the per-channel glitch-filter counter
//   chan_state_t        {level, prev, status} view of one channel
//   *_ok() functions    legal-range checks evaluated at elaboration

package pad_bank_pkg;

   localparam int unsigned MAX_WIDTH        = 32;
   localparam int unsigned FILTER_CNT_W     = 4;
   localparam int unsigned MIN_SYNC_STAGES  = 2;
   localparam int unsigned MAX_SYNC_STAGES  = 4;
   localparam int unsigned MIN_FILTER_CYCLES = 2;
   localparam int unsigned MAX_FILTER_CYCLES = 15;

   typedef struct packed {
      logic level;   // synchronised (and possibly filtered) pad level
      logic prev;    // level one cycle earlier
      logic status;  // sticky edge status
   } chan_state_t;

   function automatic bit width_ok(int unsigned n);
      return (n >= 1) && (n <= MAX_WIDTH);
   endfunction

   function automatic bit sync_stages_ok(int unsigned n);
      return (n >= MIN_SYNC_STAGES) && (n <= MAX_SYNC_STAGES);
   endfunction

   function automatic bit filter_cycles_ok(int unsigned n);
      return (n >= MIN_FILTER_CYCLES) && (n <= MAX_FILTER_CYCLES);
   endfunction

endpackage

// File: rtl/pad_bank_chan.sv
// pad_bank_chan: one pad channel input path.
//   Synchroniser of SYNC_STAGES flops, optional glitch filter (macro
//   PAD_BANK_GLITCH_FILTER_EN), rise/fall edge detect and one sticky status bit.
// Ports:
//   clk_i, rst_ni   core clock, async active-low reset
//   pad_dout_i      asynchronous pad level
//   rise_en_i       capture rising edges
//   fall_en_i       capture falling edges
//   irq_clr_i       clear pulse for the status bit
//   level_o         synchronised (filtered) level
//   status_o        sticky edge status

module pad_bank_chan
   import pad_bank_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pad_dout_i,
   input  logic rise_en_i,
   input  logic fall_en_i,
   input  logic irq_clr_i,
   output logic level_o,
   output logic status_o
);

   if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync
      $error("pad_bank_chan: SYNC_STAGES out of range");
   end
   if (!filter_cycles_ok(FILTER_CYCLES)) begin : g_bad_filter
      $error("pad_bank_chan: FILTER_CYCLES out of range");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic                   level;
   logic                   prev_q;
   logic                   status_q, status_d;
   logic                   rise, fall;
   chan_state_t            st;

   // Plain flop chain; bit 0 is the metastability-exposed stage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_dout_i};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PAD_BANK_GLITCH_FILTER_EN
   logic [FILTER_CNT_W-1:0] cnt_q, cnt_d;
   logic                    flt_q, flt_d;

   // Counter runs only while the synchroniser disagrees with the filtered
   // level; any agreement restarts it, so short pulses never get through.
   always_comb begin
      cnt_d = '0;
      flt_d = flt_q;
      if (sync_out != flt_q) begin
         if (cnt_q == FILTER_CNT_W'(FILTER_CYCLES - 1)) begin
            flt_d = ~flt_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         flt_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         flt_q <= flt_d;
      end
   end

   assign level = flt_q;
`else
   assign level = sync_out;
`endif

   always_comb begin
      st.level  = level;
      st.prev   = prev_q;
      st.status = status_q;
   end

   assign rise = st.level & ~st.prev & rise_en_i;
   assign fall = ~st.level & st.prev & fall_en_i;

   // Edge is OR-ed in after the clear, so a coincident edge wins.
   assign status_d = (st.status & ~irq_clr_i) | rise | fall;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q   <= 1'b0;
         status_q <= 1'b0;
      end else begin
         prev_q   <= st.level;
         status_q <= status_d;
      end
   end

   assign level_o  = st.level;
   assign status_o = st.status;

endmodule

// File: rtl/pad_bank_ctrl.sv
// pad_bank_ctrl: controller for one bank of bidirectional pad cells.
//   Registers output value/direction toward the pads, synchronises the pad
//   inputs and collects rise/fall edges into sticky maskable status.
//   Optional glitch filter on the input path: macro PAD_BANK_GLITCH_FILTER_EN.
// Ports:
//   clk, reset_n     core clock, async active-low reset
//   out_val, out_en  per-channel drive value and drive enable
//   pad_din, pad_oen to pad cells (pad_oen active low, 1 = hi-Z)
//   pad_dout         asynchronous level from pad cells
//   in_val           synchronised (filtered) pad level
//   rise_en, fall_en edge capture enables
//   irq_clr          per-bit status clear pulse
//   irq_status, irq  sticky status and its registered OR

module pad_bank_ctrl
   import pad_bank_pkg::*;
#(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] out_val,
   input  logic [WIDTH-1:0] out_en,
   output logic [WIDTH-1:0] pad_din,
   output logic [WIDTH-1:0] pad_oen,
   input  logic [WIDTH-1:0] pad_dout,
   output logic [WIDTH-1:0] in_val,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic [WIDTH-1:0] irq_clr,
   output logic [WIDTH-1:0] irq_status,
   output logic             irq
);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("pad_bank_ctrl: WIDTH out of range");
   end

   logic [WIDTH-1:0] din_q, din_d;
   logic [WIDTH-1:0] oen_q, oen_d;
   logic             irq_q, irq_d;

   assign din_d = out_val;
   assign oen_d = ~out_en;
   assign irq_d = |irq_status;

   // Pads come out of reset undriven (OEN high) and low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         din_q <= '0;
         oen_q <= '1;
         irq_q <= 1'b0;
      end else begin
         din_q <= din_d;
         oen_q <= oen_d;
         irq_q <= irq_d;
      end
   end

   assign pad_din = din_q;
   assign pad_oen = oen_q;
   assign irq     = irq_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      pad_bank_chan #(
         .SYNC_STAGES   (SYNC_STAGES),
         .FILTER_CYCLES (FILTER_CYCLES)
      ) u_chan (
         .clk_i      (clk),
         .rst_ni     (reset_n),
         .pad_dout_i (pad_dout[i]),
         .rise_en_i  (rise_en[i]),
         .fall_en_i  (fall_en[i]),
         .irq_clr_i  (irq_clr[i]),
         .level_o    (in_val[i]),
         .status_o   (irq_status[i])
      );
   end

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// tb_pad_bank_ctrl: directed self-checking bench for pad_bank_ctrl
// (WIDTH = 8, SYNC_STAGES = 2, FILTER_CYCLES = 4).

module tb_pad_bank_ctrl;

`ifdef PAD_BANK_GLITCH_FILTER_EN
   localparam int FLT = 4;
`else
   localparam int FLT = 0;
`endif
   localparam int SYN = 2;

   logic       clk;
   logic       reset_n;
   logic [7:0] out_val, out_en, pad_din, pad_oen, pad_dout, in_val;
   logic [7:0] rise_en, fall_en, irq_clr, irq_status;
   logic       irq;

   int total = 0;
   int bad   = 0;

   pad_bank_ctrl #(
      .WIDTH         (8),
      .SYNC_STAGES   (SYN),
      .FILTER_CYCLES (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .out_val    (out_val),
      .out_en     (out_en),
      .pad_din    (pad_din),
      .pad_oen    (pad_oen),
      .pad_dout   (pad_dout),
      .in_val     (in_val),
      .rise_en    (rise_en),
      .fall_en    (fall_en),
      .irq_clr    (irq_clr),
      .irq_status (irq_status),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [7:0] val;
      logic [7:0] en;
      logic [7:0] exp_din;
      logic [7:0] exp_oen;
   } out_vec_t;

   out_vec_t vecs [4];

   initial begin
      logic [7:0] prev_din, prev_oen;
      logic       seen;

      vecs[0] = '{8'hA5, 8'h0F, 8'hA5, 8'hF0};
      vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'h00};
      vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'hFF};
      vecs[3] = '{8'h3C, 8'h81, 8'h3C, 8'h7E};

      // Reset with random inputs
      reset_n  = 1'b0;
      out_val  = 8'($urandom);
      out_en   = 8'($urandom);
      pad_dout = 8'($urandom);
      rise_en  = 8'($urandom);
      fall_en  = 8'($urandom);
      irq_clr  = 8'($urandom);
      tick(3);
      check("rst_oen", 32'(pad_oen), 32'hFF);
      check("rst_din", 32'(pad_din), 32'h00);
      check("rst_status", 32'(irq_status), 32'h00);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_in_val", 32'(in_val), 32'h00);

      pad_dout = 8'h00;
      out_val  = 8'h00;
      out_en   = 8'h00;
      irq_clr  = 8'h00;
      rise_en  = 8'hFF;
      fall_en  = 8'hFF;
      tick(2);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("post_rst_quiet", 32'(irq_status), 32'h00);
      end
      check("post_rst_irq", 32'(irq), 32'h0);

      // Output path: table of vectors, one-cycle latency
      prev_din = 8'h00;
      prev_oen = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         out_val = vecs[i].val;
         out_en  = vecs[i].en;
         #1;
         check("out_din_hold", 32'(pad_din), 32'(prev_din));
         check("out_oen_hold", 32'(pad_oen), 32'(prev_oen));
         tick(1);
         check("out_din", 32'(pad_din), 32'(vecs[i].exp_din));
         check("out_oen", 32'(pad_oen), 32'(vecs[i].exp_oen));
         prev_din = vecs[i].exp_din;
         prev_oen = vecs[i].exp_oen;
      end
      out_en = 8'h00;

      // Rising edge on ch3, fall disabled
      rise_en  = 8'h08;
      fall_en  = 8'h00;
      pad_dout = 8'h08;
      tick(1 + FLT);
      check("rise_inval_early", 32'(in_val), 32'h00);
      tick(1);
      check("rise_inval", 32'(in_val), 32'h08);
      check("rise_status_early", 32'(irq_status), 32'h00);
      tick(1);
      check("rise_status", 32'(irq_status), 32'h08);
      check("rise_irq_early", 32'(irq), 32'h0);
      tick(1);
      check("rise_irq", 32'(irq), 32'h1);
      pad_dout = 8'h00;
      tick(SYN + FLT + 3);
      check("fall_masked_inval", 32'(in_val), 32'h00);
      check("fall_masked_status", 32'(irq_status), 32'h08);
      irq_clr = 8'h08;
      tick(1);
      irq_clr = 8'h00;
      check("clr3_status", 32'(irq_status), 32'h00);
      check("clr3_irq_lag", 32'(irq), 32'h1);
      tick(1);
      check("clr3_irq", 32'(irq), 32'h0);

      // Clear collision on ch5
      rise_en  = 8'h20;
      fall_en  = 8'h20;
      pad_dout = 8'h20;
      tick(SYN + FLT + 1);
      check("c5_rise_status", 32'(irq_status), 32'h20);
      pad_dout = 8'h00;
      tick(SYN + FLT);
      check("c5_fall_inval", 32'(in_val), 32'h00);
      irq_clr = 8'h20;
      tick(1);
      irq_clr = 8'h00;
      check("c5_collision", 32'(irq_status), 32'h20);
      check("c5_irq", 32'(irq), 32'h1);
      irq_clr = 8'h20;
      tick(1);
      irq_clr = 8'h00;
      check("c5_clear", 32'(irq_status), 32'h00);
      check("c5_irq_lag", 32'(irq), 32'h1);
      tick(1);
      check("c5_irq_drop", 32'(irq), 32'h0);

`ifdef PAD_BANK_GLITCH_FILTER_EN
      // Glitch filter on ch0
      rise_en  = 8'h01;
      fall_en  = 8'h00;
      pad_dout = 8'h01;
      tick(3);
      pad_dout = 8'h00;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         seen = seen | in_val[0];
      end
      check("glitch_blocked", 32'(seen), 32'h0);
      check("glitch_status", 32'(irq_status), 32'h00);
      pad_dout = 8'h01;
      tick(5);
      check("filter_early", 32'(in_val), 32'h00);
      tick(1);
      check("filter_pass", 32'(in_val), 32'h01);
      pad_dout = 8'h00;
      tick(12);
      irq_clr = 8'h01;
      tick(1);
      irq_clr = 8'h00;
      tick(1);
      check("filter_clr", 32'(irq_status), 32'h00);
`else
      seen = 1'b0;
`endif

      // Asynchronous reset mid-operation
      rise_en  = 8'h02;
      fall_en  = 8'h00;
      pad_dout = 8'h02;
      tick(SYN + FLT + 2);
      check("ar_irq_before", 32'(irq), 32'h1);
      pad_dout = 8'h00;
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_status", 32'(irq_status), 32'h00);
      check("ar_irq", 32'(irq), 32'h0);
      check("ar_oen", 32'(pad_oen), 32'hFF);
      #2;
      reset_n = 1'b1;
      rise_en = 8'hFF;
      fall_en = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("ar_quiet", 32'(irq_status), 32'h00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
